prbs16_checker: RTL and testbench

PRBS16_CHECKER -- requirements
Module: prbs16_checker

---
 rtl/prbs_pkg.sv | 23 ++
 rtl/prbs16_checker.sv | 126 ++++++++++++
 tb/tb_prbs16_checker.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/prbs_pkg.sv
// Shared definitions for the 16-bit XNOR PRBS generator and checker.
// Holds the checker state type, the LFSR width and tap positions, and
// the next-bit function used by both ends of the link.
package prbs_pkg;

    localparam int unsigned LFSR_W = 16;

    localparam int unsigned TAP_A = 10;
    localparam int unsigned TAP_B = 12;
    localparam int unsigned TAP_C = 13;
    localparam int unsigned TAP_D = 15;

    typedef enum logic {
        ST_SEARCH = 1'b0,
        ST_LOCKED = 1'b1
    } chk_state_t;

    // Bit shifted into the LSB on the next generator step.
    function automatic logic prbs_next_bit(input logic [LFSR_W-1:0] s);
        return ~(s[TAP_A] ^ s[TAP_B] ^ s[TAP_C] ^ s[TAP_D]);
    endfunction

endpackage

// File: rtl/prbs16_checker.sv
// PRBS16 stream checker with lock acquisition, flywheel tracking and
// windowed loss-of-lock detection.
//
// Ports:
//   i_clk      - clock, all logic on the rising edge
//   i_rst      - synchronous active-high reset
//   i_valid    - qualifies i_bit
//   i_bit      - received serial PRBS bit
//   i_clr_cnt  - synchronous clear of o_err_cnt (wins over an increment)
//   o_locked   - checker synchronized to the stream
//   o_err      - one-cycle pulse for a mismatched bit while locked
//   o_err_cnt  - saturating count of locked-mode mismatches
//
// state     | meaning
// ----------+---------------------------------------------------------
// ST_SEARCH | load history from the line, then count consecutive hits
// ST_LOCKED | history runs on its own prediction; line errors counted
module prbs16_checker
    import prbs_pkg::*;
#(
    parameter int unsigned LOCK_THRESH = 32,
    parameter int unsigned LOSS_WINDOW = 64,
    parameter int unsigned LOSS_THRESH = 8
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_valid,
    input  logic        i_bit,
    input  logic        i_clr_cnt,
    output logic        o_locked,
    output logic        o_err,
    output logic [15:0] o_err_cnt
);

    localparam int unsigned MATCH_W = $clog2(LOCK_THRESH + 1);
    localparam int unsigned WIN_W   = $clog2(LOSS_WINDOW);
    localparam int unsigned ERR_W   = $clog2(LOSS_THRESH + 1);
    localparam logic [4:0]  FILL_FULL = 5'(LFSR_W);

    chk_state_t          state;
    logic [LFSR_W-1:0]   s;
    logic [4:0]          fill;
    logic [MATCH_W-1:0]  match_cnt;
    logic [WIN_W-1:0]    win_cnt;
    logic [ERR_W-1:0]    win_err;

    logic pred;
    logic bit_ok;
    logic win_last;
    logic loss;

    assign pred     = prbs_next_bit(s);
    assign bit_ok   = (i_bit == pred);
    assign win_last = (win_cnt == WIN_W'(LOSS_WINDOW - 1));
    // The current bit is included, so an error on the closing bit of a
    // window still counts toward that window.
    assign loss     = !bit_ok && (win_err == ERR_W'(LOSS_THRESH - 1));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state     <= ST_SEARCH;
            s         <= '0;
            fill      <= '0;
            match_cnt <= '0;
            win_cnt   <= '0;
            win_err   <= '0;
            o_locked  <= 1'b0;
            o_err     <= 1'b0;
            o_err_cnt <= '0;
        end else begin
            o_err <= 1'b0;
            if (i_valid) begin
                case (state)
                    ST_SEARCH: begin
                        s <= {s[LFSR_W-2:0], i_bit};
                        if (fill != FILL_FULL) begin
                            fill <= fill + 5'd1;
                        end else if (s == '1 || !bit_ok) begin
                            // All-ones is the XNOR lockup state; it would
                            // self-predict forever, so never lock on it.
                            match_cnt <= '0;
                        end else if (match_cnt == MATCH_W'(LOCK_THRESH - 1)) begin
                            state     <= ST_LOCKED;
                            o_locked  <= 1'b1;
                            match_cnt <= '0;
                            win_cnt   <= '0;
                            win_err   <= '0;
                        end else begin
                            match_cnt <= match_cnt + 1'b1;
                        end
                    end
                    ST_LOCKED: begin
                        s <= {s[LFSR_W-2:0], pred};
                        if (!bit_ok) begin
                            o_err <= 1'b1;
                            if (o_err_cnt != '1) begin
                                o_err_cnt <= o_err_cnt + 16'd1;
                            end
                        end
                        if (loss) begin
                            state     <= ST_SEARCH;
                            o_locked  <= 1'b0;
                            fill      <= '0;
                            match_cnt <= '0;
                            win_cnt   <= '0;
                            win_err   <= '0;
                        end else if (win_last) begin
                            win_cnt <= '0;
                            win_err <= '0;
                        end else begin
                            win_cnt <= win_cnt + 1'b1;
                            if (!bit_ok) begin
                                win_err <= win_err + 1'b1;
                            end
                        end
                    end
                    default: state <= ST_SEARCH;
                endcase
            end
            if (i_clr_cnt) begin
                o_err_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_prbs16_checker.sv
module tb_prbs16_checker;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, valid, bitv, clr;
    logic        locked, err;
    logic [15:0] cnt;

    logic        s_rst, s_valid, s_bit, s_clr;
    logic        s_locked, s_err;
    logic [15:0] s_cnt;

    prbs16_checker u_dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_valid   (valid),
        .i_bit     (bitv),
        .i_clr_cnt (clr),
        .o_locked  (locked),
        .o_err     (err),
        .o_err_cnt (cnt)
    );

    // Window can never reach its error threshold, so every bit can be an
    // error while locked; used to drive the counter into saturation.
    prbs16_checker #(
        .LOCK_THRESH (32),
        .LOSS_WINDOW (64),
        .LOSS_THRESH (100)
    ) u_sat (
        .i_clk     (clk),
        .i_rst     (s_rst),
        .i_valid   (s_valid),
        .i_bit     (s_bit),
        .i_clr_cnt (s_clr),
        .o_locked  (s_locked),
        .o_err     (s_err),
        .o_err_cnt (s_cnt)
    );

    typedef struct {
        string       tag;
        logic        locked;
        logic        err;
        logic [15:0] cnt;
    } exp_t;

    exp_t        sb_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [15:0] gs;
    logic [15:0] exp_cnt;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic gen(output logic b);
        b  = ~(gs[10] ^ gs[12] ^ gs[13] ^ gs[15]);
        gs = {gs[14:0], b};
    endtask

    task automatic step(input string tag, input logic r, input logic v, input logic b,
                        input logic c, input logic e_lock, input logic e_err);
        exp_t e;
        rst   = r;
        valid = v;
        bitv  = b;
        clr   = c;
        e.tag = tag; e.locked = e_lock; e.err = e_err; e.cnt = exp_cnt;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        check({e.tag, "_locked"}, 32'(locked), 32'(e.locked));
        check({e.tag, "_err"},    32'(err),    32'(e.err));
        check({e.tag, "_cnt"},    32'(cnt),    32'(e.cnt));
    endtask

    task automatic send_clean(input string tag, input int n, input logic e_lock);
        logic b;
        for (int i = 0; i < n; i++) begin
            gen(b);
            step(tag, 1'b0, 1'b1, b, 1'b0, e_lock, 1'b0);
        end
    endtask

    task automatic send_err(input string tag, input logic e_lock);
        logic b;
        gen(b);
        exp_cnt = exp_cnt + 16'd1;
        step(tag, 1'b0, 1'b1, ~b, 1'b0, e_lock, 1'b1);
    endtask

    task automatic lock_run(input string tag);
        logic b;
        for (int i = 1; i <= 48; i++) begin
            gen(b);
            step(tag, 1'b0, 1'b1, b, 1'b0, (i == 48), 1'b0);
        end
    endtask

    task automatic sat_cycle(input logic r, input logic v, input logic b, input logic c);
        s_rst   = r;
        s_valid = v;
        s_bit   = b;
        s_clr   = c;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic b;
        int   nv;
        rst = 1'b1; valid = 1'b0; bitv = 1'b0; clr = 1'b0;
        s_rst = 1'b1; s_valid = 1'b0; s_bit = 1'b0; s_clr = 1'b0;
        exp_cnt = '0;
        gs = '0;
        @(posedge clk);
        #1;

        // Reset, including valid traffic during reset
        step("reset_v", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        step("reset",   1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Lock after 16 fill + 32 matches
        gs = '0;
        lock_run("lock");

        // Single error while locked
        send_clean("locked_clean", 10, 1'b1);
        send_err("single_err", 1'b1);
        send_clean("after_err", 53, 1'b1);

        // 8 errors in a fresh window -> loss on the 8th
        for (int k = 0; k < 8; k++) begin
            send_err("burst_err", (k < 7));
            if (k < 7) send_clean("burst_gap", 1, 1'b1);
        end
        lock_run("relock");

        // 7 errors closing a window, then 1 in the next: stays locked
        send_clean("win_a", 57, 1'b1);
        for (int k = 0; k < 7; k++) send_err("win_a_err", 1'b1);
        send_err("win_b_first", 1'b1);
        // 8th error of the window lands on its closing bit -> loss
        send_clean("win_b", 56, 1'b1);
        for (int k = 0; k < 7; k++) send_err("win_b_err", (k < 6));

        // Counter clear in search mode
        gen(b);
        exp_cnt = '0;
        step("clr", 1'b0, 1'b1, b, 1'b1, 1'b0, 1'b0);

        // All-ones lockup stream never locks
        step("rst_ones", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 100; i++) step("all_ones", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);

        // Valid toggling: lock after exactly 48 valid bits, garbage ignored
        step("rst_tog", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        gs = '0;
        nv = 0;
        while (nv < 58) begin
            gen(b);
            nv++;
            step("tog_valid", 1'b0, 1'b1, b, 1'b0, (nv >= 48), 1'b0);
            step("tog_idle", 1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'b0, (nv >= 48), 1'b0);
        end

        // Reset mid-lock, then full refill + 32 matches to relock
        step("mid_rst", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        lock_run("relock_rst");
        valid = 1'b0;
        rst   = 1'b0;
        check("sb_empty", 32'(sb_q.size()), 32'd0);

        // Saturation on the second instance
        sat_cycle(1'b1, 1'b0, 1'b0, 1'b0);
        check("sat_reset_locked", 32'(s_locked), 32'd0);
        check("sat_reset_cnt", 32'(s_cnt), 32'd0);
        gs = '0;
        for (int i = 0; i < 48; i++) begin
            gen(b);
            sat_cycle(1'b0, 1'b1, b, 1'b0);
        end
        check("sat_lock", 32'(s_locked), 32'd1);
        for (int i = 0; i < 65534; i++) begin
            gen(b);
            sat_cycle(1'b0, 1'b1, ~b, 1'b0);
        end
        check("sat_fffe", 32'(s_cnt), 32'hFFFE);
        gen(b);
        sat_cycle(1'b0, 1'b1, ~b, 1'b0);
        check("sat_ffff", 32'(s_cnt), 32'hFFFF);
        gen(b);
        sat_cycle(1'b0, 1'b1, ~b, 1'b0);
        check("sat_hold_cnt", 32'(s_cnt), 32'hFFFF);
        check("sat_hold_err", 32'(s_err), 32'd1);
        check("sat_hold_locked", 32'(s_locked), 32'd1);
        gen(b);
        sat_cycle(1'b0, 1'b1, ~b, 1'b1);
        check("sat_clr_cnt", 32'(s_cnt), 32'd0);
        check("sat_clr_err", 32'(s_err), 32'd1);
        gen(b);
        sat_cycle(1'b0, 1'b1, ~b, 1'b0);
        check("sat_after_clr", 32'(s_cnt), 32'd1);
        gen(b);
        sat_cycle(1'b0, 1'b1, b, 1'b0);
        check("sat_clean_err", 32'(s_err), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected end of test");
        $fatal(1, "watchdog");
    end

endmodule
